// File: rtl/gcn_matmul_seq.sv
// Sequential dense matrix multiplier R = A x B for the GCN datapath.
// One inner-index step per clock across COLS parallel MACs; one result row per handshake.
module gcn_matmul_seq #(
    parameter int ROWS   = 6,
    parameter int INNER  = 96,
    parameter int COLS   = 3,
    parameter int IN_W   = 6,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_wr_en,
    input  logic [$clog2(ROWS*INNER)-1:0] a_wr_addr,
    input  logic [IN_W-1:0]               a_wr_data,
    input  logic                          b_wr_en,
    input  logic [$clog2(INNER)-1:0]      b_wr_addr,
    input  logic [COLS*IN_W-1:0]          b_wr_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(ROWS)-1:0]       res_row,
    output logic [COLS*ACC_W-1:0]         res_data
);

    localparam int AW     = $clog2(ROWS*INNER);
    localparam int BW     = $clog2(INNER);
    localparam int RW     = $clog2(ROWS);
    localparam int FULL_W = 2*IN_W + $clog2(INNER) + 1;
    localparam int EW     = ((FULL_W > ACC_W) ? FULL_W : ACC_W) + 1;

    localparam logic signed [EW-1:0] U_MAX = {{(EW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic signed [EW-1:0] S_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] S_MIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} stateT;

    stateT state, stateNext;

    logic [IN_W-1:0]      aMem [ROWS*INNER];
    logic [COLS*IN_W-1:0] bMem [INNER];

    logic [RW-1:0]     rowIdx;
    logic [BW-1:0]     innerIdx;
    logic [FULL_W-1:0] acc  [COLS];
    logic [FULL_W-1:0] prod [COLS];
    logic [AW-1:0]     aRdAddr;
    logic [IN_W-1:0]   aRd;
    logic [COLS*IN_W-1:0] bRd;
    logic handshake, lastInner, lastRow, idle;

    function automatic logic [FULL_W-1:0] extend(input logic [IN_W-1:0] v);
        if (SIGNED != 0) return {{(FULL_W-IN_W){v[IN_W-1]}}, v};
        return {{(FULL_W-IN_W){1'b0}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] convert(input logic [FULL_W-1:0] v);
        logic signed [EW-1:0] x;
        logic signed [EW-1:0] hi;
        if (SIGNED != 0) x = $signed({{(EW-FULL_W){v[FULL_W-1]}}, v});
        else             x = $signed({{(EW-FULL_W){1'b0}}, v});
        hi = (SIGNED != 0) ? S_MAX : U_MAX;
        if (SAT == 0)                  return x[ACC_W-1:0];
        if (x > hi)                    return hi[ACC_W-1:0];
        if (SIGNED != 0 && x < S_MIN)  return S_MIN[ACC_W-1:0];
        return x[ACC_W-1:0];
    endfunction

    assign idle      = (state == IDLE);
    assign handshake = res_valid && res_ready;
    assign lastInner = (innerIdx == BW'(INNER-1));
    assign lastRow   = (rowIdx == RW'(ROWS-1));
    assign aRdAddr   = AW'(int'(rowIdx) * INNER + int'(innerIdx));
    assign aRd       = aMem[aRdAddr];
    assign bRd       = bMem[innerIdx];

    // NOTE: storage has no reset so it maps onto plain RAM and survives a reset.
    always_ff @(posedge clk) begin
        if (idle && a_wr_en && int'(a_wr_addr) < ROWS*INNER) aMem[a_wr_addr] <= a_wr_data;
        if (idle && b_wr_en && int'(b_wr_addr) < INNER)      bMem[b_wr_addr] <= b_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = MAC;
            MAC:     if (lastInner) stateNext = OUT;
            OUT:     if (handshake) stateNext = lastRow ? IDLE : MAC;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy      = !idle;
        res_valid = (state == OUT);
    end

    always_comb begin
        for (int k = 0; k < COLS; k++) prod[k] = extend(aRd) * extend(bRd[k*IN_W +: IN_W]);
    end

    // NOTE: nonblocking assignments keep every register reading pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowIdx   <= '0;
            innerIdx <= '0;
            done     <= 1'b0;
            for (int k = 0; k < COLS; k++) acc[k] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rowIdx   <= '0;
                        innerIdx <= '0;
                    end
                end
                MAC: begin
                    for (int k = 0; k < COLS; k++)
                        acc[k] <= (innerIdx == '0) ? prod[k] : acc[k] + prod[k];
                    innerIdx <= lastInner ? '0 : innerIdx + 1'b1;
                end
                OUT: begin
                    if (handshake) begin
                        innerIdx <= '0;
                        if (lastRow) done   <= 1'b1;
                        else         rowIdx <= rowIdx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_row = rowIdx;

    // NOTE: a default ahead of the loop keeps this block free of latches.
    always_comb begin
        res_data = '0;
        for (int k = 0; k < COLS; k++) res_data[k*ACC_W +: ACC_W] = convert(acc[k]);
    end

endmodule

// File: tb/tb_gcn_matmul_seq.sv
// Bench for gcn_matmul_seq: four instances (SIGNED x SAT) share stimulus and are
// compared every cycle against a plain-arithmetic matrix model and spec timing.
module tb_gcn_matmul_seq;

    localparam int ROWS  = 6;
    localparam int INNER = 96;
    localparam int COLS  = 3;
    localparam int NDUT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_wr_en = 1'b0;
    logic [9:0]  a_wr_addr = '0;
    logic [5:0]  a_wr_data = '0;
    logic        b_wr_en = 1'b0;
    logic [6:0]  b_wr_addr = '0;
    logic [17:0] b_wr_data = '0;
    logic        start = 1'b0;
    logic        res_ready = 1'b0;

    logic        busyV  [NDUT];
    logic        doneV  [NDUT];
    logic        validV [NDUT];
    logic [2:0]  rowV   [NDUT];
    logic [47:0] dataV  [NDUT];

    logic [5:0] refA [ROWS][INNER];
    logic [5:0] refB [INNER][COLS];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gcn_matmul_seq #(.SIGNED(0), .SAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .start(start),
        .busy(busyV[0]), .done(doneV[0]), .res_valid(validV[0]), .res_ready(res_ready),
        .res_row(rowV[0]), .res_data(dataV[0]));
    gcn_matmul_seq #(.SIGNED(0), .SAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .start(start),
        .busy(busyV[1]), .done(doneV[1]), .res_valid(validV[1]), .res_ready(res_ready),
        .res_row(rowV[1]), .res_data(dataV[1]));
    gcn_matmul_seq #(.SIGNED(1), .SAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .start(start),
        .busy(busyV[2]), .done(doneV[2]), .res_valid(validV[2]), .res_ready(res_ready),
        .res_row(rowV[2]), .res_data(dataV[2]));
    gcn_matmul_seq #(.SIGNED(1), .SAT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .start(start),
        .busy(busyV[3]), .done(doneV[3]), .res_valid(validV[3]), .res_ready(res_ready),
        .res_row(rowV[3]), .res_data(dataV[3]));

    task automatic check(input string tag, input int d, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic longint val(input logic [5:0] x, input bit sg);
        if (sg && x[5]) return longint'(x) - 64;
        return longint'(x);
    endfunction

    // Expected row r for instance d: bit 1 of d selects signed, bit 0 selects saturation.
    function automatic logic [47:0] expRow(input int d, input int r);
        bit sg = (d / 2) != 0;
        bit sat = (d % 2) != 0;
        longint s;
        logic [15:0] e;
        logic [47:0] res = '0;
        for (int k = 0; k < COLS; k++) begin
            s = 0;
            for (int j = 0; j < INNER; j++) s += val(refA[r][j], sg) * val(refB[j][k], sg);
            if (!sat)         e = s[15:0];
            else if (!sg)     e = (s > 65535) ? 16'hFFFF : s[15:0];
            else if (s > 32767)  e = 16'h7FFF;
            else if (s < -32768) e = 16'h8000;
            else              e = s[15:0];
            res[k*16 +: 16] = e;
        end
        return res;
    endfunction

    task automatic wrA(input int i, input int j, input logic [5:0] v);
        a_wr_en = 1'b1; a_wr_addr = 10'(i*INNER + j); a_wr_data = v;
        refA[i][j] = v;
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic wrB(input int j, input logic [17:0] v);
        b_wr_en = 1'b1; b_wr_addr = 7'(j); b_wr_data = v;
        for (int k = 0; k < COLS; k++) refB[j][k] = v[k*6 +: 6];
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    // mode 0: constant c everywhere, 1: identity-like A with B[j][k]=j+k, 2: random
    task automatic loadMats(input int mode, input logic [5:0] c);
        logic [17:0] row;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < INNER; j++)
                wrA(i, j, (mode == 0) ? c : (mode == 1) ? 6'(i == j) : 6'($urandom));
        for (int j = 0; j < INNER; j++) begin
            for (int k = 0; k < COLS; k++)
                row[k*6 +: 6] = (mode == 0) ? c : (mode == 1) ? 6'(j + k) : 6'($urandom);
            wrB(j, row);
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check({tag, "_busy"},  d, 48'(busyV[d]),  48'd0);
            check({tag, "_done"},  d, 48'(doneV[d]),  48'd0);
            check({tag, "_valid"}, d, 48'(validV[d]), 48'd0);
            check({tag, "_row"},   d, 48'(rowV[d]),   48'd0);
            check({tag, "_data"},  d, dataV[d],       48'd0);
        end
    endtask

    // Starts a run at the current negedge and follows it to the done cycle.
    task automatic runMatmul(input bit randReady, input bit timing, input bit disturb,
                             input int abortCyc, input bit startWrite);
        int cyc, row, lastHs, nextValid;
        bit expValid, expDone, finished;
        logic [47:0] expD;
        start = 1'b1;
        if (startWrite) begin
            a_wr_en = 1'b1; a_wr_addr = 10'd5; a_wr_data = ~refA[0][5];
            refA[0][5] = ~refA[0][5];
        end
        @(negedge clk);
        start = 1'b0; a_wr_en = 1'b0;
        cyc = 1; row = 0; lastHs = 0; nextValid = INNER + 1; finished = 1'b0;
        while (!finished && cyc < 2000) begin
            if (timing) begin
                expValid = (row < ROWS) && (cyc == (row + 1) * (INNER + 1));
                expDone  = (cyc == ROWS * (INNER + 1) + 1);
            end else begin
                expValid = (row < ROWS) && (cyc >= nextValid);
                expDone  = (row == ROWS) && (cyc == lastHs + 1);
            end
            if (abortCyc != 0 && cyc == abortCyc) begin
                rst_n = 1'b0;
                #1;
                checkResetState("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            for (int d = 0; d < NDUT; d++) begin
                check("busy",  d, 48'(busyV[d]),  48'(!expDone));
                check("done",  d, 48'(doneV[d]),  48'(expDone));
                check("valid", d, 48'(validV[d]), 48'(expValid));
                if (expValid) begin
                    expD = expRow(d, row);
                    check("row",  d, 48'(rowV[d]), 48'(row));
                    check("data", d, dataV[d], expD);
                end
            end
            if (expDone) begin
                finished = 1'b1;
            end else begin
                if (disturb && (cyc == 50 || cyc == 300)) begin
                    start = 1'b1;
                    a_wr_en = 1'b1; a_wr_addr = 10'($urandom_range(0, ROWS*INNER-1)); a_wr_data = 6'($urandom);
                    b_wr_en = 1'b1; b_wr_addr = 7'($urandom_range(0, INNER-1)); b_wr_data = 18'($urandom);
                end else begin
                    start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
                end
                res_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
                if (expValid && res_ready) begin
                    row++;
                    lastHs = cyc;
                    nextValid = cyc + INNER + 1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
        total++;
        assert (finished) else begin
            bad++;
            $error("FAIL run_timeout observed_cycles=%0d expected=done", cyc);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        loadMats(0, 6'd1);
        runMatmul(1'b0, 1'b1, 1'b0, 0, 1'b0);
        loadMats(0, 6'd63);
        runMatmul(1'b0, 1'b1, 1'b0, 0, 1'b0);
        loadMats(0, 6'd32);
        runMatmul(1'b0, 1'b1, 1'b0, 0, 1'b0);

        loadMats(1, 6'd0);
        runMatmul(1'b1, 1'b0, 1'b0, 0, 1'b0);

        loadMats(2, 6'd0);
        runMatmul(1'b1, 1'b0, 1'b1, 0, 1'b0);

        // Out-of-range writes must leave storage untouched.
        a_wr_en = 1'b1; b_wr_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            a_wr_addr = 10'($urandom_range(ROWS*INNER, 1023)); a_wr_data = 6'($urandom);
            b_wr_addr = 7'($urandom_range(INNER, 127));        b_wr_data = 18'($urandom);
            @(negedge clk);
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        runMatmul(1'b1, 1'b0, 1'b0, 0, 1'b1);

        loadMats(2, 6'd0);
        runMatmul(1'b0, 1'b1, 1'b0, 2*(INNER+1) + 40, 1'b0);
        runMatmul(1'b0, 1'b1, 1'b0, 0, 1'b0);
        runMatmul(1'b0, 1'b1, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcn_matmul_seq.md
# gcn_matmul_seq

Sequential, parametrised dense matrix multiplier for the GCN datapath: computes R = A × B, where A is a ROWS×INNER feature matrix and B is an INNER×COLS weight matrix.
- Both matrices are loaded through write ports into internal storage.
- Computation is triggered by a start pulse and runs one inner-index step per clock, with COLS parallel MACs.
- One result row is streamed out per valid/ready handshake.
- Sits between the feature/weight loaders and the aggregation stage; replaces the earlier simulation-only multiplier with synthesizable hardware.

## Interface
- ROWS, 6, rows of A and R
- INNER, 96, columns of A / rows of B
- COLS, 3, columns of B and R
- IN_W, 6, element width of A and B
- ACC_W, 16, output element width
- SIGNED, 0, 0 = unsigned operands/results, 1 = two's complement
- SAT, 0, 0 = output truncated to low ACC_W bits, 1 = output clamped to ACC_W range
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_wr_en  in  1  write A element
- a_wr_addr  in  clog2(ROWS*INNER)  linear address i*INNER+j
- a_wr_data  in  IN_W  A[i][j]
- b_wr_en  in  1  write one B row
- b_wr_addr  in  clog2(INNER)  row index j
- b_wr_data  in  COLS*IN_W  B[j][k] at bits [k*IN_W +: IN_W]
- start  in  1  begin multiplication (sampled in IDLE only)
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after last row handshake
- res_valid  out  1  result row available
- res_ready  in  1  consumer accepts row
- res_row  out  clog2(ROWS)  row index i of res_data
- res_data  out  COLS*ACC_W  R[i][k] at bits [k*ACC_W +: ACC_W]

## Operation
- States:
  - IDLE: busy = 0. Accepted start resets i to 0 and j to 0, then goes to MAC.
  - MAC: runs for INNER cycles.
    - At j = 0, each acc[k] loads A[i][0]*B[0][k]; otherwise acc[k] += A[i][j]*B[j][k].
    - After j = INNER-1, goes to OUT.
  - OUT: res_valid = 1; res_data and res_row are held stable until the handshake (res_valid & res_ready).
    - On handshake with i < ROWS-1: i++, j = 0, back to MAC.
    - On handshake with i = ROWS-1: goes to IDLE and pulses done.
- Arithmetic:
  - Products are full 2*IN_W-bit values, signed or unsigned per SIGNED.
  - The accumulator is FULL_W = 2*IN_W + clog2(INNER) + 1 bits, so it never overflows internally.
- Output conversion, applied combinationally from acc:
  - SAT = 0: low ACC_W bits of acc.
  - SAT = 1, SIGNED = 0: min(acc, 2^ACC_W-1).
  - SAT = 1, SIGNED = 1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Writes:
  - Accepted only when busy = 0; ignored while busy.
  - Out-of-range addresses are ignored.
  - A and B storage is not reset and keeps contents across runs and across reset.
- start while busy = 1 is ignored.
- Simultaneous write and start in IDLE: the write commits, and MAC uses the new value (writes land at the same edge as start acceptance, before the first MAC read).

## Timing
- Reset values: busy 0, done 0, res_valid 0, res_row 0, res_data 0 (acc cleared), state IDLE.
- Asynchronous reset mid-run aborts immediately to IDLE; no done pulse is issued.
- Start sampled high at edge 0:
  - MAC occupies cycles 1..INNER.
  - res_valid rises in cycle INNER+1.
- With res_ready held at 1, row r is valid in cycle (r+1)*(INNER+1).
- done is high exactly one cycle after the last handshake; busy falls in that same cycle.
- For defaults, row 0 is valid in cycle 97 and row 5 in cycle 582; done and busy-low occur in cycle 583.
- Backpressure: each cycle with res_ready = 0 in OUT adds one cycle; no result is dropped or duplicated.
- A new start is accepted in the done cycle or any later cycle.

## Test plan
- Defaults, A and B all 1, res_ready = 1 -> six rows, every element 96, res_row 0..5 in order, valid in cycles 97, 194, …, 582, done in 583.
- Defaults, A and B all 63 -> every element 53344 (381024 mod 65536); repeat with SAT = 1 -> 65535.
- SIGNED = 1, A and B all -32:
  - SAT = 0 -> every element 0x8000 (-32768).
  - SAT = 1 -> 32767.
- Identity-like A (A[i][i] = 1, else 0) with B[j][k] = j+k -> R[i][k] = i+k; res_ready toggled randomly -> data held stable while stalled, no loss.
- start pulsed mid-run and writes attempted while busy -> run unaffected, memories unchanged, only one done pulse.
- rst_n asserted in MAC of row 2 -> outputs return to reset values immediately, no done; a new start then yields correct results from retained memories.
